traffic_light_monitor: RTL and testbench
========================================

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter MIN_RED, default 1: minimum legal RED dwell, in cycles.
REQ-003 Parameter MAX_RED, default 1: maximum legal RED dwell, in cycles.
REQ-004 Parameter MIN_GREEN / MAX_GREEN, default 1 / 1: GREEN dwell bounds, in cycles.
REQ-005 Parameter MIN_YELLOW / MAX_YELLOW, default 1 / 1: YELLOW dwell bounds, in cycles.
REQ-006 Port clock  input  1: rising-edge clock, shared with the light source.
REQ-007 Port reset_n  input  1: asynchronous active-low reset.
REQ-008 Port light_in  input  3: sampled lamp code, bit2=red, bit1=green, bit0=yellow; legal codes 100, 010, 001.
REQ-009 Port clear_err  input  1: synchronous clear of all sticky error flags.
REQ-010 Port mon_state  output  2: tracker state, SYNC=0, RED=1, GREEN=2, YELLOW=3.
REQ-011 Port dwell  output  8: cycles spent in the current code, saturating at 255.
REQ-012 Port err_onehot  output  1: sticky flag, non-one-hot code seen.
REQ-013 Port err_seq  output  1: sticky flag, legal code seen out of R->G->Y->R order.
REQ-014 Port err_dwell  output  1: sticky flag, dwell bound violated.
REQ-015 Port err_any  output  1: OR of the three error flags.
REQ-016 Port cycle_count  output  16: completed R->G->Y->R cycles, saturating at 65535.

Function
REQ-017 light_in SHALL be sampled on every rising clock edge; all outputs SHALL be registered, except err_any, which is combinational from the registered flags.
REQ-018 Each output SHALL reflect a given sample one cycle after that sample.
REQ-019 In SYNC, a sample of 100 SHALL move the state to RED with dwell=1; any other sample SHALL stay in SYNC with no error raised.
REQ-020 In RED/GREEN/YELLOW, a sample equal to the current code SHALL increment dwell, saturating at 255.
REQ-021 err_dwell SHALL set when dwell would exceed the state's MAX_*.
REQ-022 A sample equal to the next legal code (RED->010, GREEN->001, YELLOW->100) SHALL advance the state and set dwell=1.
REQ-023 On a legal advance, err_dwell SHALL set if the exiting dwell was below the state's MIN_*.
REQ-024 A YELLOW->RED advance SHALL increment cycle_count.
REQ-025 A non-one-hot sample (000, 011, 101, 110, 111) outside SYNC SHALL set err_onehot and return the state to SYNC with dwell=0.
REQ-026 A one-hot sample that is neither the current code nor the next legal code SHALL set err_seq and return the state to SYNC with dwell=0.
REQ-027 The error flags SHALL be sticky until clear_err or reset.
REQ-028 If clear_err and a new error occur in the same cycle, the new error's flag SHALL be set and the other flags cleared.
REQ-029 clear_err SHALL NOT affect mon_state, dwell or cycle_count.
REQ-030 Dwell saturation at 255 SHALL NOT by itself wrap dwell or clear any flag.

Reset
REQ-031 While reset_n=0, outputs SHALL be: mon_state=SYNC, dwell=0, all error flags 0, cycle_count=0.
REQ-032 Reset asserted mid-cycle SHALL abandon tracking; the first sample of 100 after release SHALL start a fresh RED.

Configuration
REQ-033 With macro TLM_CYCLE_CNT_EN defined, cycle_count SHALL operate per REQ-024 and REQ-016.
REQ-034 Without TLM_CYCLE_CNT_EN, cycle_count SHALL be constant 0, and its counter register SHALL NOT be instantiated.

Verification
REQ-035 Default parameters, reset_n low then high, light_in 100,010,001 repeated 4 times then 100 -> no errors, cycle_count=4, mon_state cycles 1,2,3.
REQ-036 light_in 100, 010, then 110 -> err_onehot=1 one cycle after 110, mon_state=0, err_any=1.
REQ-037 light_in 100, 001 -> err_seq=1, mon_state=0; then clear_err pulse -> err_seq=0, mon_state still 0.
REQ-038 MAX_GREEN=3, GREEN held 4 samples -> err_dwell=1 on the 4th sample; MIN_RED=2, RED held 1 sample then 010 -> err_dwell=1.
REQ-039 clear_err=1 in the same cycle as an illegal 111 sample -> err_onehot=1 afterward, err_seq and err_dwell=0.
REQ-040 reset_n pulsed low mid-GREEN -> all outputs return to reset values immediately; 010 after release keeps mon_state=0; 100 then gives mon_state=1.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Watches a sampled traffic-light lamp code and tracks the R->G->Y->R
//   sequence. It flags non-one-hot codes, out-of-order codes and dwell-time
//   violations with sticky error flags, and counts completed light cycles.
//
// Optional feature macro: TLM_CYCLE_CNT_EN
//   defined   : cycle_count counts completed R->G->Y->R cycles (saturating)
//   undefined : cycle_count is tied to 0 and no counter register exists
//
// Ports
//   clock        in   rising-edge clock, shared with the light source
//   reset_n      in   asynchronous active-low reset
//   light_in     in   [2:0] lamp code, bit2=red bit1=green bit0=yellow
//   clear_err    in   synchronous clear of the sticky error flags
//   mon_state    out  [1:0] tracker state: SYNC=0 RED=1 GREEN=2 YELLOW=3
//   dwell        out  [7:0] cycles in the current code, saturating at 255
//   err_onehot   out  sticky: non-one-hot code seen
//   err_seq      out  sticky: legal code seen out of order
//   err_dwell    out  sticky: dwell bound violated
//   err_any      out  OR of the three error flags (combinational)
//   cycle_count  out  [15:0] completed cycles, saturating at 65535
module traffic_light_monitor #(
  parameter int unsigned MIN_RED    = 1,
  parameter int unsigned MAX_RED    = 1,
  parameter int unsigned MIN_GREEN  = 1,
  parameter int unsigned MAX_GREEN  = 1,
  parameter int unsigned MIN_YELLOW = 1,
  parameter int unsigned MAX_YELLOW = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  light_in,
  input  logic        clear_err,
  output logic [1:0]  mon_state,
  output logic [7:0]  dwell,
  output logic        err_onehot,
  output logic        err_seq,
  output logic        err_dwell,
  output logic        err_any,
  output logic [15:0] cycle_count
);

  localparam logic [1:0] ST_SYNC   = 2'd0;
  localparam logic [1:0] ST_RED    = 2'd1;
  localparam logic [1:0] ST_GREEN  = 2'd2;
  localparam logic [1:0] ST_YELLOW = 2'd3;

  localparam logic [2:0] CODE_RED    = 3'b100;
  localparam logic [2:0] CODE_GREEN  = 3'b010;
  localparam logic [2:0] CODE_YELLOW = 3'b001;

  logic [2:0]  cur_code;
  logic [2:0]  next_code;
  logic [1:0]  adv_state;
  logic [31:0] min_dwell;
  logic [31:0] max_dwell;
  logic [31:0] dwell_ext;
  logic        is_onehot;

  logic [1:0]  state_d;
  logic [7:0]  dwell_d;
  logic        ev_onehot;
  logic        ev_seq;
  logic        ev_dwell;

  // Per-state lamp code, successor and dwell bounds.
  always_comb begin
    cur_code  = CODE_RED;
    next_code = CODE_GREEN;
    adv_state = ST_GREEN;
    min_dwell = MIN_RED;
    max_dwell = MAX_RED;
    case (mon_state)
      ST_GREEN: begin
        cur_code  = CODE_GREEN;
        next_code = CODE_YELLOW;
        adv_state = ST_YELLOW;
        min_dwell = MIN_GREEN;
        max_dwell = MAX_GREEN;
      end
      ST_YELLOW: begin
        cur_code  = CODE_YELLOW;
        next_code = CODE_RED;
        adv_state = ST_RED;
        min_dwell = MIN_YELLOW;
        max_dwell = MAX_YELLOW;
      end
      default: ;
    endcase
  end

  assign is_onehot = (light_in == CODE_RED) || (light_in == CODE_GREEN) ||
                     (light_in == CODE_YELLOW);
  assign dwell_ext = {24'd0, dwell};

  always_comb begin
    state_d   = mon_state;
    dwell_d   = dwell;
    ev_onehot = 1'b0;
    ev_seq    = 1'b0;
    ev_dwell  = 1'b0;
    if (mon_state == ST_SYNC) begin
      // Anything other than red while hunting is silently ignored.
      if (light_in == CODE_RED) begin
        state_d = ST_RED;
        dwell_d = 8'd1;
      end
    end else if (light_in == cur_code) begin
      // Bound is checked on the unsaturated count so a long hold keeps
      // reporting even once dwell has pinned at 255.
      if (dwell_ext + 32'd1 > max_dwell) ev_dwell = 1'b1;
      if (dwell != 8'hFF) dwell_d = dwell + 8'd1;
    end else if (light_in == next_code) begin
      if (dwell_ext < min_dwell) ev_dwell = 1'b1;
      state_d = adv_state;
      dwell_d = 8'd1;
    end else if (!is_onehot) begin
      ev_onehot = 1'b1;
      state_d   = ST_SYNC;
      dwell_d   = 8'd0;
    end else begin
      ev_seq  = 1'b1;
      state_d = ST_SYNC;
      dwell_d = 8'd0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mon_state  <= ST_SYNC;
      dwell      <= '0;
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;
      err_dwell  <= 1'b0;
    end else begin
      mon_state  <= state_d;
      dwell      <= dwell_d;
      // A fresh event wins over a simultaneous clear.
      err_onehot <= (err_onehot & ~clear_err) | ev_onehot;
      err_seq    <= (err_seq    & ~clear_err) | ev_seq;
      err_dwell  <= (err_dwell  & ~clear_err) | ev_dwell;
    end
  end

  assign err_any = err_onehot | err_seq | err_dwell;

`ifdef TLM_CYCLE_CNT_EN
  logic        cycle_done;
  logic [15:0] cycle_q;

  assign cycle_done = (mon_state == ST_YELLOW) && (light_in == CODE_RED);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q <= '0;
    end else if (cycle_done && (cycle_q != '1)) begin
      cycle_q <= cycle_q + 16'd1;
    end
  end

  assign cycle_count = cycle_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Testbench for traffic_light_monitor. Two instances: u0 with default
// parameters, u1 with MIN_RED=2, MAX_RED=2, MAX_GREEN=3. Expected output
// snapshots come from a small behavioural model, pushed when a sample is
// driven and popped one cycle later when the DUT has registered it.
module tb_traffic_light_monitor;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  light0 = 3'b000;
  logic [2:0]  light1 = 3'b000;
  logic        clr0 = 1'b0;
  logic        clr1 = 1'b0;

  logic [1:0]  ms0, ms1;
  logic [7:0]  dw0, dw1;
  logic        eo0, es0, ed0, ea0;
  logic        eo1, es1, ed1, ea1;
  logic [15:0] cc0, cc1;

  always #5 clock = ~clock;

  traffic_light_monitor u0 (
    .clock(clock), .reset_n(reset_n), .light_in(light0), .clear_err(clr0),
    .mon_state(ms0), .dwell(dw0), .err_onehot(eo0), .err_seq(es0),
    .err_dwell(ed0), .err_any(ea0), .cycle_count(cc0)
  );

  traffic_light_monitor #(
    .MIN_RED(2), .MAX_RED(2), .MIN_GREEN(1), .MAX_GREEN(3),
    .MIN_YELLOW(1), .MAX_YELLOW(1)
  ) u1 (
    .clock(clock), .reset_n(reset_n), .light_in(light1), .clear_err(clr1),
    .mon_state(ms1), .dwell(dw1), .err_onehot(eo1), .err_seq(es1),
    .err_dwell(ed1), .err_any(ea1), .cycle_count(cc1)
  );

  // Snapshot layout: state, dwell, eo, es, ed, any, cycle_count
  logic [29:0] obs0, obs1;
  assign obs0 = {ms0, dw0, eo0, es0, ed0, ea0, cc0};
  assign obs1 = {ms1, dw1, eo1, es1, ed1, ea1, cc1};

  logic [29:0] q0[$];
  logic [29:0] q1[$];

  int checks = 0;
  int errors = 0;

  // Behavioural model state, indexed by instance
  logic [1:0]  m_st [2];
  int unsigned m_dw [2];
  bit          m_eo [2];
  bit          m_es [2];
  bit          m_ed [2];
  int unsigned m_cc [2];

  function automatic void mreset(input int k);
    m_st[k] = 2'd0; m_dw[k] = 0; m_eo[k] = 0; m_es[k] = 0; m_ed[k] = 0; m_cc[k] = 0;
  endfunction

  function automatic logic [29:0] mobs(input int k);
    return {m_st[k], 8'(m_dw[k]), m_eo[k], m_es[k], m_ed[k],
            m_eo[k] | m_es[k] | m_ed[k], 16'(m_cc[k])};
  endfunction

  function automatic void mstep(input int k, input logic [2:0] l, input logic c);
    logic [2:0]  cur, nxt;
    int unsigned mn, mx;
    bit          eo, es, ed;
    eo = 0; es = 0; ed = 0; mn = 1; mx = 1;
    if (c) begin m_eo[k] = 0; m_es[k] = 0; m_ed[k] = 0; end
    if (m_st[k] == 2'd0) begin
      if (l == 3'b100) begin m_st[k] = 2'd1; m_dw[k] = 1; end
    end else begin
      cur = 3'b100 >> (int'(m_st[k]) - 1);
      nxt = (m_st[k] == 2'd3) ? 3'b100 : (cur >> 1);
      case (m_st[k])
        2'd1: begin mn = (k == 1) ? 2 : 1; mx = (k == 1) ? 2 : 1; end
        2'd2: begin mn = 1; mx = (k == 1) ? 3 : 1; end
        default: begin mn = 1; mx = 1; end
      endcase
      if (l == cur) begin
        if (m_dw[k] + 1 > mx) ed = 1;
        if (m_dw[k] < 255) m_dw[k] = m_dw[k] + 1;
      end else if (l == nxt) begin
        if (m_dw[k] < mn) ed = 1;
`ifdef TLM_CYCLE_CNT_EN
        if (m_st[k] == 2'd3 && m_cc[k] < 65535) m_cc[k] = m_cc[k] + 1;
`endif
        m_st[k] = (m_st[k] == 2'd3) ? 2'd1 : 2'(m_st[k] + 2'd1);
        m_dw[k] = 1;
      end else if ($countones(l) != 1) begin
        eo = 1; m_st[k] = 2'd0; m_dw[k] = 0;
      end else begin
        es = 1; m_st[k] = 2'd0; m_dw[k] = 0;
      end
    end
    if (eo) m_eo[k] = 1;
    if (es) m_es[k] = 1;
    if (ed) m_ed[k] = 1;
  endfunction

  // Leaves reset released at a falling edge; the caller drives immediately.
  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    light0 = 3'b000; light1 = 3'b000; clr0 = 1'b0; clr1 = 1'b0;
    mreset(0); mreset(1);
    q0.delete(); q1.delete();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset_n = 1'b0;
    light0 = 3'b100; light1 = 3'b100;
    #1;
    checks++;
    if (obs0 !== 30'h0) begin errors++; $display("FAIL reset_u0 got %h expected %h", obs0, 30'h0); end
    checks++;
    if (obs1 !== 30'h0) begin errors++; $display("FAIL reset_u1 got %h expected %h", obs1, 30'h0); end
    @(negedge clock);
    checks++;
    if (obs0 !== 30'h0) begin errors++; $display("FAIL reset_hold got %h expected %h", obs0, 30'h0); end
    reset_n = 1'b1;
    light0 = 3'b000; light1 = 3'b000;
    mreset(0); mreset(1);
  endtask

  task automatic test_normal_cycles();
    logic [2:0]  ls [13] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b100,
                             3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b100};
    logic [29:0] e;
    logic [15:0] cc_exp;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      light0 = ls[i]; clr0 = 1'b0;
      mstep(0, ls[i], 1'b0); q0.push_back(mobs(0));
      @(negedge clock);
      e = q0.pop_front();
      checks++;
      if (obs0 !== e) begin errors++; $display("FAIL normal_cycles row %0d got %h expected %h", i, obs0, e); end
    end
`ifdef TLM_CYCLE_CNT_EN
    cc_exp = 16'd4;
`else
    cc_exp = 16'd0;
`endif
    checks++;
    if (cc0 !== cc_exp || ea0 !== 1'b0 || ms0 !== 2'd1)
      begin errors++; $display("FAIL normal_cycles_end got cc=%0d any=%b st=%0d expected cc=%0d any=0 st=1", cc0, ea0, ms0, cc_exp); end
  endtask

  task automatic test_onehot();
    logic [2:0]  ls [3] = '{3'b100, 3'b010, 3'b110};
    logic [29:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      light0 = ls[i]; clr0 = 1'b0;
      mstep(0, ls[i], 1'b0); q0.push_back(mobs(0));
      @(negedge clock);
      e = q0.pop_front();
      checks++;
      if (obs0 !== e) begin errors++; $display("FAIL onehot row %0d got %h expected %h", i, obs0, e); end
    end
    checks++;
    if ({eo0, ms0, ea0} !== {1'b1, 2'd0, 1'b1})
      begin errors++; $display("FAIL onehot_flags got eo=%b st=%0d any=%b expected eo=1 st=0 any=1", eo0, ms0, ea0); end
  endtask

  task automatic test_seq_clear();
    logic [2:0]  ls [3] = '{3'b100, 3'b001, 3'b000};
    logic        cs [3] = '{1'b0, 1'b0, 1'b1};
    logic [29:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      light0 = ls[i]; clr0 = cs[i];
      mstep(0, ls[i], cs[i]); q0.push_back(mobs(0));
      @(negedge clock);
      e = q0.pop_front();
      checks++;
      if (obs0 !== e) begin errors++; $display("FAIL seq_clear row %0d got %h expected %h", i, obs0, e); end
      if (i == 1) begin
        checks++;
        if ({es0, ms0} !== {1'b1, 2'd0})
          begin errors++; $display("FAIL seq_flag got es=%b st=%0d expected es=1 st=0", es0, ms0); end
      end
    end
    clr0 = 1'b0;
    checks++;
    if ({es0, ms0} !== {1'b0, 2'd0})
      begin errors++; $display("FAIL seq_cleared got es=%b st=%0d expected es=0 st=0", es0, ms0); end
  endtask

  task automatic test_clear_collision();
    logic [2:0]  ls [5] = '{3'b100, 3'b100, 3'b001, 3'b100, 3'b111};
    logic        cs [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [29:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      light0 = ls[i]; clr0 = cs[i];
      mstep(0, ls[i], cs[i]); q0.push_back(mobs(0));
      @(negedge clock);
      e = q0.pop_front();
      checks++;
      if (obs0 !== e) begin errors++; $display("FAIL clear_collision row %0d got %h expected %h", i, obs0, e); end
    end
    clr0 = 1'b0;
    checks++;
    if ({eo0, es0, ed0} !== 3'b100)
      begin errors++; $display("FAIL clear_collision_flags got %b expected 100", {eo0, es0, ed0}); end
  endtask

  task automatic test_dwell_saturation();
    logic [29:0] e;
    logic [2:0]  l;
    do_reset();
    for (int i = 0; i < 301; i++) begin
      l = (i < 300) ? 3'b100 : 3'b010;
      light0 = l; clr0 = 1'b0;
      mstep(0, l, 1'b0); q0.push_back(mobs(0));
      @(negedge clock);
      e = q0.pop_front();
      checks++;
      if (obs0 !== e) begin errors++; $display("FAIL dwell_sat row %0d got %h expected %h", i, obs0, e); end
      if (i == 299) begin
        checks++;
        if ({dw0, ed0} !== {8'd255, 1'b1})
          begin errors++; $display("FAIL dwell_sat_pin got dw=%0d ed=%b expected dw=255 ed=1", dw0, ed0); end
      end
    end
  endtask

  task automatic test_dwell_bounds();
    logic [2:0]  la [6] = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b010, 3'b010};
    logic [2:0]  lb [2] = '{3'b100, 3'b010};
    logic [29:0] e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      light1 = la[i]; clr1 = 1'b0;
      mstep(1, la[i], 1'b0); q1.push_back(mobs(1));
      @(negedge clock);
      e = q1.pop_front();
      checks++;
      if (obs1 !== e) begin errors++; $display("FAIL max_green row %0d got %h expected %h", i, obs1, e); end
      checks++;
      if (ed1 !== (i == 5)) begin errors++; $display("FAIL max_green_flag row %0d got %b expected %b", i, ed1, (i == 5)); end
    end
    do_reset();
    for (int i = 0; i < 2; i++) begin
      light1 = lb[i]; clr1 = 1'b0;
      mstep(1, lb[i], 1'b0); q1.push_back(mobs(1));
      @(negedge clock);
      e = q1.pop_front();
      checks++;
      if (obs1 !== e) begin errors++; $display("FAIL min_red row %0d got %h expected %h", i, obs1, e); end
    end
    checks++;
    if ({ed1, ms1} !== {1'b1, 2'd2})
      begin errors++; $display("FAIL min_red_flag got ed=%b st=%0d expected ed=1 st=2", ed1, ms1); end
  endtask

  task automatic test_reset_mid();
    logic [2:0]  la [3] = '{3'b100, 3'b010, 3'b010};
    logic [2:0]  lb [2] = '{3'b010, 3'b100};
    logic [29:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      light0 = la[i]; clr0 = 1'b0;
      mstep(0, la[i], 1'b0); q0.push_back(mobs(0));
      @(negedge clock);
      e = q0.pop_front();
      checks++;
      if (obs0 !== e) begin errors++; $display("FAIL reset_mid pre row %0d got %h expected %h", i, obs0, e); end
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (obs0 !== 30'h0) begin errors++; $display("FAIL reset_mid_async got %h expected %h", obs0, 30'h0); end
    mreset(0); mreset(1); q0.delete();
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      light0 = lb[i]; clr0 = 1'b0;
      mstep(0, lb[i], 1'b0); q0.push_back(mobs(0));
      @(negedge clock);
      e = q0.pop_front();
      checks++;
      if (obs0 !== e) begin errors++; $display("FAIL reset_mid post row %0d got %h expected %h", i, obs0, e); end
    end
    checks++;
    if ({ms0, dw0} !== {2'd1, 8'd1})
      begin errors++; $display("FAIL reset_mid_red got st=%0d dw=%0d expected st=1 dw=1", ms0, dw0); end
  endtask

  initial begin
    mreset(0); mreset(1);
    test_reset();
    test_normal_cycles();
    test_onehot();
    test_seq_clear();
    test_clear_collision();
    test_dwell_saturation();
    test_dwell_bounds();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
